// File: rtl/led_pkg.sv
// LED bank driver shared types.
// Display mode encoding for the mode input.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t MODE_LATCH = 2'd0;
  localparam led_mode_t MODE_BLINK = 2'd1;
  localparam led_mode_t MODE_PWM   = 2'd2;
  localparam led_mode_t MODE_SHIFT = 2'd3;

endpackage

// File: rtl/led_tick_gen.sv
// Wrap counter: tick on the last count, flag toggles on each wrap.
// Ports: clk, reset (async high) in; tick, flag out.
module led_tick_gen #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic flag
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      flag <= ~flag;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_bank_driver.sv
// LED bank driver: latch/blink/PWM/shift user LEDs plus hb/activity.
// Ports: clk, reset, data, data_valid, mode in; leds, led_hb, led_act out.
module led_bank_driver
  import led_pkg::*;
#(
  parameter int N_LEDS       = 7,
  parameter int DATA_W       = 8,
  parameter int HB_PERIOD    = 200_000_000,
  parameter int BLINK_PERIOD = 25_000_000,
  parameter int PWM_W        = 8,
  parameter int STRETCH      = 2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  input  led_mode_t         mode,
  output logic [N_LEDS-1:0] leds,
  output logic              led_hb,
  output logic              led_act
);

  localparam int SW = $clog2(STRETCH + 1);
  // Strobe cycle drives led_act itself; the counter holds the rest.
  localparam logic [SW-1:0] STR_LOAD = SW'(STRETCH - 1);

  logic              hb_tick;
  logic              hb_flap;
  logic              blink_tick;
  logic              blink_phase;
  logic [N_LEDS-1:0] pattern;
  logic [N_LEDS-1:0] shifted;
  logic [N_LEDS-1:0] leds_next;
  logic [PWM_W-1:0]  duty;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [SW-1:0]     stretch_cnt;
  logic              pwm_on;
  logic              unused_ok;

  led_tick_gen #(.PERIOD(HB_PERIOD)) u_hb (
    .clk   (clk),
    .reset (reset),
    .tick  (hb_tick),
    .flag  (hb_flap)
  );

  led_tick_gen #(.PERIOD(BLINK_PERIOD)) u_blink (
    .clk   (clk),
    .reset (reset),
    .tick  (blink_tick),
    .flag  (blink_phase)
  );

  assign unused_ok = ^{hb_tick, blink_tick, data};

  assign led_hb = reset | hb_flap;
  assign pwm_on = (pwm_cnt < duty);

  generate
    if (N_LEDS == 1) begin : g_shift1
      assign shifted = data[0];
    end else begin : g_shiftn
      assign shifted = {pattern[N_LEDS-2:0], data[0]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= '0;
      duty    <= '0;
    end else if (data_valid) begin
      unique case (mode)
        MODE_LATCH,
        MODE_BLINK: pattern <= data[N_LEDS-1:0];
        MODE_PWM:   duty    <= data[PWM_W-1:0];
        MODE_SHIFT: pattern <= shifted;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stretch_cnt <= '0;
      led_act     <= 1'b0;
    end else begin
      if (data_valid)
        stretch_cnt <= STR_LOAD;
      else if (stretch_cnt != '0)
        stretch_cnt <= stretch_cnt - 1'b1;
      led_act <= (stretch_cnt != '0) || data_valid;
    end
  end

  always_comb begin
    leds_next = pattern;
    unique case (mode)
      MODE_LATCH: leds_next = pattern;
      MODE_BLINK: leds_next = pattern & {N_LEDS{blink_phase}};
      MODE_PWM:   leds_next = pattern & {N_LEDS{pwm_on}};
      MODE_SHIFT: leds_next = pattern;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leds <= '0;
    else       leds <= leds_next;
  end

endmodule

// File: tb/tb_led_bank_driver.sv
// Randomized + directed bench for led_bank_driver.
// Reference model derives counters from elapsed cycles.
module tb_led_bank_driver;

  localparam int N  = 7;
  localparam int HB = 10;
  localparam int BP = 4;
  localparam int ST = 3;
  localparam int PW = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   data = '0;
  logic         dv = 1'b0;
  logic [1:0]   mode = '0;
  logic [N-1:0] leds;
  logic         led_hb;
  logic         led_act;

  int checks = 0;
  int errors = 0;

  int         e;
  logic [6:0] pat;
  logic [7:0] duty;
  int         last_strobe;
  bit         has_strobe;

  led_bank_driver #(
    .N_LEDS       (N),
    .DATA_W       (8),
    .HB_PERIOD    (HB),
    .BLINK_PERIOD (BP),
    .PWM_W        (PW),
    .STRETCH      (ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .data_valid (dv),
    .mode       (mode),
    .leds       (leds),
    .led_hb     (led_hb),
    .led_act    (led_act)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e           = 0;
    pat         = '0;
    duty        = '0;
    last_strobe = 0;
    has_strobe  = 0;
  endtask

  // One clock: drive, advance, predict from elapsed cycles, compare.
  task automatic step(input logic [1:0] m, input logic v,
                      input logic [7:0] d);
    logic [6:0] el;
    bit         blink;
    bit         pon;
    bit         act;
    mode = m;
    dv   = v;
    data = d;
    @(posedge clk);
    #1;
    blink = ((e / BP) % 2) == 1;
    pon   = (e % (1 << PW)) < int'(duty);
    case (m)
      2'd1:    el = blink ? pat : 7'd0;
      2'd2:    el = pon ? pat : 7'd0;
      default: el = pat;
    endcase
    if (v) begin
      case (m)
        2'd2:    duty = d;
        2'd3:    pat  = {pat[5:0], d[0]};
        default: pat  = d[6:0];
      endcase
      last_strobe = e;
      has_strobe  = 1;
    end
    act = has_strobe && ((e - last_strobe) < ST);
    e++;
    check("leds", 32'(leds), 32'(el));
    check("led_act", 32'(led_act), 32'(act));
    check("led_hb", 32'(led_hb), 32'((e / HB) % 2));
    dv = 1'b0;
  endtask

  task automatic idle(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) step(m, 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    check("rst_hb", 32'(led_hb), 32'd1);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_act", 32'(led_act), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rel_hb", 32'(led_hb), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0,
           8'($urandom));

    // Mid-run reset
    step(2'd0, 1'b1, 8'h7F);
    reset = 1'b1;
    #1;
    check("mid_hb", 32'(led_hb), 32'd1);
    check("mid_leds", 32'(leds), 32'd0);
    check("mid_act", 32'(led_act), 32'd0);
    @(posedge clk);
    #1;
    check("mid_hold_hb", 32'(led_hb), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rel_hb", 32'(led_hb), 32'd0);
    idle(2'd0, 9);
    check("hb_pre", 32'(led_hb), 32'd0);
    idle(2'd0, 1);
    check("hb_first", 32'(led_hb), 32'd1);

    // Latch + activity window
    step(2'd0, 1'b1, 8'hA5);
    n = int'(led_act);
    step(2'd0, 1'b0, 8'h00);
    check("latch_a5", 32'(leds), 32'h25);
    n += int'(led_act);
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b0, 8'h00);
      n += int'(led_act);
    end
    check("act_len", 32'(n), 32'd3);

    // Blink
    step(2'd0, 1'b1, 8'h7F);
    idle(2'd1, 16);

    // PWM duty 0x40 then 0
    step(2'd0, 1'b1, 8'h0F);
    step(2'd2, 1'b1, 8'h40);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      step(2'd2, 1'b0, 8'h00);
      if (leds == 7'h0F) n++;
    end
    check("pwm_64", 32'(n), 32'd64);
    step(2'd2, 1'b1, 8'h00);
    step(2'd2, 1'b0, 8'h00);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      step(2'd2, 1'b0, 8'h00);
      if (leds != 7'h00) n++;
    end
    check("pwm_0", 32'(n), 32'd0);

    // Shift marquee, mode change on the first strobe
    step(2'd0, 1'b1, 8'h00);
    step(2'd3, 1'b1, 8'h01);
    step(2'd3, 1'b1, 8'h00);
    step(2'd3, 1'b1, 8'h01);
    step(2'd3, 1'b1, 8'h01);
    step(2'd3, 1'b0, 8'h00);
    check("shift_0b", 32'(leds), 32'h0B);

    // Retriggered activity
    idle(2'd0, 5);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b1, 8'h11);
      if (led_act) n++;
      step(2'd0, 1'b0, 8'h00);
      if (led_act) n++;
    end
    check("act_held", 32'(n), 32'd6);
    step(2'd0, 1'b0, 8'h00);
    check("act_tail", 32'(led_act), 32'd1);
    step(2'd0, 1'b0, 8'h00);
    check("act_off", 32'(led_act), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
